// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM states, buffer entry layout and widths.
package fetch_pkg;

   localparam int PC_W    = 9;
   localparam int INSTR_W = 9;
   localparam logic [INSTR_W-1:0] HALT_WORD = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of fetched words; entry 0 is always the head, so head is a plain register.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  fetch_entry_t din,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t entry0;
   fetch_entry_t entry1;
   logic         pop_ok;

   assign pop_ok = pop & (count != 2'd0);
   assign head   = entry0;

   // A push lands in the slot that will be the tail after this cycle's pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         entry0 <= '0;
         entry1 <= '0;
      end else if (clear) begin
         count <= 2'd0;
      end else begin
         if (pop_ok)
            entry0 <= entry1;
         if (push) begin
            if ((count == 2'd0) || ((count == 2'd1) && pop_ok))
               entry0 <= din;
            else
               entry1 <= din;
         end
         count <= count + {1'b0, push} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: FSM, issue/replay redirect, in-flight tag and HALT detection.
// Optional perf counters are built when INSTR_FETCH_PERF_EN is defined.
module instr_fetch
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               flush,
   input  logic [PC_W-1:0]    pc_in,
   output logic               imem_en,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic               redir_valid,
   output logic [PC_W-1:0]    redir_addr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic               done
`ifdef INSTR_FETCH_PERF_EN
   ,
   output logic [15:0]        perf_fetched,
   output logic [15:0]        perf_stalls
`endif
);

   fetch_state_t    state;
   fetch_state_t    state_n;
   logic            inflight;
   logic [PC_W-1:0] inflight_pc;
   logic [1:0]      count;
   fetch_entry_t    head;
   fetch_entry_t    ret_entry;
   logic            issue;
   logic            push;
   logic            pop;
   logic            clear;
   logic [2:0]      occupancy;

   assign out_valid  = (count != 2'd0);
   assign pop        = out_valid & out_ready;
   assign out_instr  = head.instr;
   assign out_pc     = head.pc;
   assign done       = (state == HALT) && (count == 2'd0);
   assign imem_addr  = pc_in;
   assign redir_addr = pc_in;
   assign imem_en    = issue;
   assign clear      = start | flush;
   assign occupancy  = {1'b0, count} + {2'b0, inflight};

   // Returning words are dropped once halted or when squashed this cycle.
   assign push            = inflight & (state == RUN) & ~clear;
   assign ret_entry.pc    = inflight_pc;
   assign ret_entry.instr = imem_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Issue only if the buffer can still hold the word when it returns; otherwise replay the PC.
   always_comb begin
      state_n     = state;
      issue       = 1'b0;
      redir_valid = 1'b0;
      if (start) begin
         state_n = RUN;
      end else if (!flush && (state == RUN)) begin
         if (occupancy <= (3'd1 + {2'b0, pop}))
            issue = 1'b1;
         else
            redir_valid = 1'b1;
         if (push && (imem_data == HALT_WORD))
            state_n = HALT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= issue;
         if (issue)
            inflight_pc <= pc_in;
      end
   end

   fetch_skid_buf u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clear (clear),
      .din   (ret_entry),
      .count (count),
      .head  (head)
   );

`ifdef INSTR_FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= 16'd0;
         perf_stalls  <= 16'd0;
      end else if (start) begin
         perf_fetched <= 16'd0;
         perf_stalls  <= 16'd0;
      end else begin
         if (push && (perf_fetched != 16'hFFFF))
            perf_fetched <= perf_fetched + 16'd1;
         if ((state == RUN) && redir_valid && (perf_stalls != 16'hFFFF))
            perf_stalls <= perf_stalls + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC model and a synchronous instruction memory.
// Perf counter checks are compiled in when INSTR_FETCH_PERF_EN is defined.
module tb_instr_fetch;
   import fetch_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               flush;
   logic [PC_W-1:0]    pc_in;
   logic               imem_en;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               redir_valid;
   logic [PC_W-1:0]    redir_addr;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic               done;
`ifdef INSTR_FETCH_PERF_EN
   logic [15:0]        perf_fetched;
   logic [15:0]        perf_stalls;
`endif

   logic [PC_W-1:0]    start_addr;
   logic [PC_W-1:0]    flush_target;
   logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
   int                 test_count = 0;
   int                 fail_count = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .flush       (flush),
      .pc_in       (pc_in),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .redir_valid (redir_valid),
      .redir_addr  (redir_addr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .done        (done)
`ifdef INSTR_FETCH_PERF_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_stalls (perf_stalls)
`endif
   );

   // Program counter: start loads, flush jumps, replay holds, otherwise increments.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc_in <= '0;
      else if (start)
         pc_in <= start_addr;
      else if (flush)
         pc_in <= flush_target;
      else if (redir_valid)
         pc_in <= redir_addr;
      else
         pc_in <= pc_in + 1'b1;
   end

   always @(posedge clk) begin
      if (imem_en)
         imem_data <= mem[imem_addr];
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      test_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic fl, input logic rdy);
      @(posedge clk);
      #1;
      start     = st;
      flush     = fl;
      out_ready = rdy;
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1)
         checkOutput("occupancy_le_2", {15'd0, dut.u_buf.count <= 2'd2}, 16'd1);
   end

   initial begin
      for (int i = 0; i < (1 << PC_W); i++)
         mem[i] = INSTR_W'(i);
      rst_n        = 1'b0;
      start        = 1'b0;
      flush        = 1'b0;
      out_ready    = 1'b1;
      start_addr   = 9'h010;
      flush_target = 9'h040;
      #2;
      checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
      checkOutput("rst_imem_en", 16'(imem_en), 16'd0);
      checkOutput("rst_redir_valid", 16'(redir_valid), 16'd0);
      checkOutput("rst_done", 16'(done), 16'd0);
      checkOutput("rst_out_instr", 16'(out_instr), 16'd0);
      checkOutput("rst_out_pc", 16'(out_pc), 16'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Start at 0x010 and stream with decode always ready.
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("start_no_issue", 16'(imem_en), 16'd0);
      checkOutput("start_no_redir", 16'(redir_valid), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("first_issue", 16'(imem_en), 16'd1);
      checkOutput("first_addr", 16'(imem_addr), 16'h010);
      checkOutput("first_no_redir", 16'(redir_valid), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("lat_not_yet", 16'(out_valid), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("lat_valid", 16'(out_valid), 16'd1);
      checkOutput("lat_pc", 16'(out_pc), 16'h010);
      checkOutput("lat_instr", 16'(out_instr), 16'h010);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("stream_pc1", 16'(out_pc), 16'h011);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("stream_pc2", 16'(out_pc), 16'h012);
      checkOutput("stream_no_redir", 16'(redir_valid), 16'd0);

      // Decode stalls for three cycles.
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("stall0_pc", 16'(out_pc), 16'h013);
      checkOutput("stall0_redir", 16'(redir_valid), 16'd1);
      checkOutput("stall0_redir_addr", 16'(redir_addr), 16'h015);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("stall1_pc", 16'(out_pc), 16'h013);
      checkOutput("stall1_redir", 16'(redir_valid), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("stall2_instr", 16'(out_instr), 16'h013);
      checkOutput("stall2_redir_addr", 16'(redir_addr), 16'h015);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("release_redir", 16'(redir_valid), 16'd0);
      checkOutput("release_issue", 16'(imem_en), 16'd1);
      checkOutput("release_addr", 16'(imem_addr), 16'h015);
      checkOutput("release_pc", 16'(out_pc), 16'h013);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("resume_pc4", 16'(out_pc), 16'h014);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("resume_pc5", 16'(out_pc), 16'h015);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("resume_pc6", 16'(out_pc), 16'h016);

      // Flush to 0x040 with a word buffered and one in flight.
      flush_target = 9'h040;
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("flush_no_issue", 16'(imem_en), 16'd0);
      checkOutput("flush_no_redir", 16'(redir_valid), 16'd0);
      checkOutput("flush_head", 16'(out_pc), 16'h017);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("flush_cleared", 16'(out_valid), 16'd0);
      checkOutput("flush_target_addr", 16'(imem_addr), 16'h040);
      checkOutput("flush_target_issue", 16'(imem_en), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("flush_squashed", 16'(out_valid), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("flush_first_valid", 16'(out_valid), 16'd1);
      checkOutput("flush_first_pc", 16'(out_pc), 16'h040);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("flush_second_pc", 16'(out_pc), 16'h041);

      // HALT word at 0x014.
      mem[9'h014] = HALT_WORD;
      start_addr  = 9'h010;
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("halt_start_no_issue", 16'(imem_en), 16'd0);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("halt_run_pc0", 16'(out_pc), 16'h010);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("halt_word_pc", 16'(out_pc), 16'h014);
      checkOutput("halt_word_instr", 16'(out_instr), 16'h1FF);
      checkOutput("halt_not_done", 16'(done), 16'd0);
      checkOutput("halt_no_issue", 16'(imem_en), 16'd0);
      checkOutput("halt_no_redir", 16'(redir_valid), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("halt_drained", 16'(out_valid), 16'd0);
      checkOutput("halt_done", 16'(done), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("halt_no_0x015", 16'(out_valid), 16'd0);
      checkOutput("halt_done_hold", 16'(done), 16'd1);
      checkOutput("halt_idle_fetch", 16'(imem_en), 16'd0);
      mem[9'h014] = 9'h014;

      // Asynchronous reset mid-stream.
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("prereset_pc", 16'(out_pc), 16'h012);
      rst_n = 1'b0;
      #1;
      checkOutput("async_out_valid", 16'(out_valid), 16'd0);
      checkOutput("async_out_pc", 16'(out_pc), 16'd0);
      checkOutput("async_out_instr", 16'(out_instr), 16'd0);
      checkOutput("async_imem_en", 16'(imem_en), 16'd0);
      checkOutput("async_redir", 16'(redir_valid), 16'd0);
      checkOutput("async_done", 16'(done), 16'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Start and flush together: start wins.
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
      start_addr   = 9'h020;
      flush_target = 9'h040;
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("both_no_issue", 16'(imem_en), 16'd0);
      checkOutput("both_no_redir", 16'(redir_valid), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("both_issue", 16'(imem_en), 16'd1);
      checkOutput("both_addr", 16'(imem_addr), 16'h020);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("both_empty", 16'(out_valid), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("both_first_valid", 16'(out_valid), 16'd1);
      checkOutput("both_first_pc", 16'(out_pc), 16'h020);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("both_second_pc", 16'(out_pc), 16'h021);

`ifdef INSTR_FETCH_PERF_EN
      // Five buffer writes, then three replay cycles.
      start_addr = 9'h010;
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("perf_fetched", perf_fetched, 16'd5);
      checkOutput("perf_stalls", perf_stalls, 16'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
